// File: rtl/pwm_meas.sv
// Pulse-width and period meter for an asynchronous PWM line.
// Reports 12-bit saturating high time and rising-to-rising period with one-cycle strobes.
module pwm_meas (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_en,
    input  logic        i_pwm,
    output logic [11:0] o_width,
    output logic        o_wvalid,
    output logic        o_wovf,
    output logic [11:0] o_period,
    output logic        o_pvalid,
    output logic        o_povf,
    output logic        o_busy,
    output logic [1:0]  o_dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARM  = 2'd1,
        S_HIGH = 2'd2,
        S_LOW  = 2'd3
    } state_t;

    localparam logic [11:0] CNT_MAX = 12'hFFF;

    logic        r_sync1, r_sync2, r_prev;
    state_t      r_state, w_state_nxt;
    logic [11:0] r_hi_cnt, r_per_cnt, w_hi_nxt, w_per_nxt;
    logic        r_hi_ovf, r_per_ovf, w_hi_ovf_nxt, w_per_ovf_nxt;
    logic        w_rise, w_fall, w_wpub, w_ppub;
    logic [11:0] w_hi_inc, w_per_inc;
    logic        w_hi_sat, w_per_sat;

    // Publish stage: captures a finished measurement, then drives the outputs one edge later.
    logic        r_wpub, r_ppub, r_wdat_ovf, r_pdat_ovf;
    logic [11:0] r_wdat, r_pdat;
    logic [11:0] r_width, r_period;
    logic        r_wvalid, r_wovf, r_pvalid, r_povf;

    assign w_rise    = r_sync2 & ~r_prev;
    assign w_fall    = ~r_sync2 & r_prev;
    assign w_hi_sat  = (r_hi_cnt == CNT_MAX);
    assign w_per_sat = (r_per_cnt == CNT_MAX);
    assign w_hi_inc  = w_hi_sat ? r_hi_cnt : r_hi_cnt + 12'd1;
    assign w_per_inc = w_per_sat ? r_per_cnt : r_per_cnt + 12'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_prev    <= 1'b0;
            r_state   <= S_IDLE;
            r_hi_cnt  <= 12'd0;
            r_per_cnt <= 12'd0;
            r_hi_ovf  <= 1'b0;
            r_per_ovf <= 1'b0;
        end else begin
            r_sync1   <= i_pwm;
            r_sync2   <= r_sync1;
            r_prev    <= r_sync2;
            r_state   <= w_state_nxt;
            r_hi_cnt  <= w_hi_nxt;
            r_per_cnt <= w_per_nxt;
            r_hi_ovf  <= w_hi_ovf_nxt;
            r_per_ovf <= w_per_ovf_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_hi_nxt      = r_hi_cnt;
        w_per_nxt     = r_per_cnt;
        w_hi_ovf_nxt  = r_hi_ovf;
        w_per_ovf_nxt = r_per_ovf;
        w_wpub        = 1'b0;
        w_ppub        = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_hi_nxt      = 12'd0;
                w_per_nxt     = 12'd0;
                w_hi_ovf_nxt  = 1'b0;
                w_per_ovf_nxt = 1'b0;
                if (i_en) w_state_nxt = S_ARM;
            end
            S_ARM: begin
                if (w_rise) begin
                    w_hi_nxt      = 12'd1;
                    w_per_nxt     = 12'd1;
                    w_hi_ovf_nxt  = 1'b0;
                    w_per_ovf_nxt = 1'b0;
                    w_state_nxt   = S_HIGH;
                end
            end
            S_HIGH: begin
                if (w_fall) begin
                    w_wpub        = 1'b1;
                    w_per_nxt     = w_per_inc;
                    w_per_ovf_nxt = r_per_ovf | w_per_sat;
                    w_state_nxt   = S_LOW;
                end else if (r_sync2) begin
                    w_hi_nxt      = w_hi_inc;
                    w_hi_ovf_nxt  = r_hi_ovf | w_hi_sat;
                    w_per_nxt     = w_per_inc;
                    w_per_ovf_nxt = r_per_ovf | w_per_sat;
                end
            end
            S_LOW: begin
                if (w_rise) begin
                    w_ppub        = 1'b1;
                    w_hi_nxt      = 12'd1;
                    w_per_nxt     = 12'd1;
                    w_hi_ovf_nxt  = 1'b0;
                    w_per_ovf_nxt = 1'b0;
                    w_state_nxt   = S_HIGH;
                end else begin
                    w_per_nxt     = w_per_inc;
                    w_per_ovf_nxt = r_per_ovf | w_per_sat;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        // Disable discards any partial measurement without publishing it.
        if (!i_en) begin
            w_state_nxt = S_IDLE;
            w_wpub      = 1'b0;
            w_ppub      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wpub     <= 1'b0;
            r_ppub     <= 1'b0;
            r_wdat     <= 12'd0;
            r_pdat     <= 12'd0;
            r_wdat_ovf <= 1'b0;
            r_pdat_ovf <= 1'b0;
            r_width    <= 12'd0;
            r_period   <= 12'd0;
            r_wvalid   <= 1'b0;
            r_pvalid   <= 1'b0;
            r_wovf     <= 1'b0;
            r_povf     <= 1'b0;
        end else begin
            r_wpub   <= w_wpub;
            r_ppub   <= w_ppub;
            r_wvalid <= r_wpub;
            r_pvalid <= r_ppub;
            if (w_wpub) begin
                r_wdat     <= r_hi_cnt;
                r_wdat_ovf <= r_hi_ovf;
            end
            if (w_ppub) begin
                r_pdat     <= r_per_cnt;
                r_pdat_ovf <= r_per_ovf;
            end
            if (r_wpub) begin
                r_width <= r_wdat;
                r_wovf  <= r_wdat_ovf;
            end
            if (r_ppub) begin
                r_period <= r_pdat;
                r_povf   <= r_pdat_ovf;
            end
        end
    end

    assign o_width     = r_width;
    assign o_wvalid    = r_wvalid;
    assign o_wovf      = r_wovf;
    assign o_period    = r_period;
    assign o_pvalid    = r_pvalid;
    assign o_povf      = r_povf;
    assign o_busy      = (r_state == S_HIGH) || (r_state == S_LOW);
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_pwm_meas.sv
// Bench for pwm_meas: timestamp-based reference model checked every cycle,
// directed scenarios with literal report checks, then randomized PWM traffic.
module tb_pwm_meas;

    logic        clk = 1'b0;
    logic        rst, i_en, i_pwm;
    logic [11:0] o_width, o_period;
    logic        o_wvalid, o_wovf, o_pvalid, o_povf, o_busy;
    logic [1:0]  o_dbg_state;

    int checks = 0;
    int errors = 0;

    pwm_meas dut (
        .clk        (clk),
        .rst        (rst),
        .i_en       (i_en),
        .i_pwm      (i_pwm),
        .o_width    (o_width),
        .o_wvalid   (o_wvalid),
        .o_wovf     (o_wovf),
        .o_period   (o_period),
        .o_pvalid   (o_pvalid),
        .o_povf     (o_povf),
        .o_busy     (o_busy),
        .o_dbg_state(o_dbg_state)
    );

    always #5 clk = ~clk;

    // Reference model: line seen through two sync stages, measurements are
    // differences of edge timestamps, reported one edge after detection.
    int          cyc = 0;
    bit          m_started = 0;
    int          m_mode = 0;   // 0 idle, 1 armed, 2 measuring
    int          m_rise_edge = 0;
    bit          h0, h1, h2, h3;
    bit          pw = 0, pp = 0, pw_o, pp_o;
    logic [11:0] pw_v, pp_v;
    logic [11:0] e_width = 0, e_period = 0;
    logic        e_wvalid = 0, e_wovf = 0, e_pvalid = 0, e_povf = 0, e_busy = 0;

    always @(posedge clk) begin
        int len;
        bit rise, fall;
        cyc++;
        if (rst) begin
            m_started = 1;
            m_mode = 0;
            {h0, h1, h2, h3} = 4'b0;
            pw = 0; pp = 0;
            e_width = 0; e_period = 0;
            e_wvalid = 0; e_wovf = 0; e_pvalid = 0; e_povf = 0; e_busy = 0;
        end else begin
            e_wvalid = pw;
            e_pvalid = pp;
            if (pw) begin e_width = pw_v; e_wovf = pw_o; end
            if (pp) begin e_period = pp_v; e_povf = pp_o; end
            pw = 0; pp = 0;
            h3 = h2; h2 = h1; h1 = h0; h0 = i_pwm;
            rise = h2 && !h3;
            fall = !h2 && h3;
            if (!i_en) m_mode = 0;
            else if (m_mode == 0) m_mode = 1;
            else if (m_mode == 1) begin
                if (rise) begin m_mode = 2; m_rise_edge = cyc; end
            end else begin
                len = cyc - m_rise_edge;
                if (fall) begin
                    pw = 1; pw_o = (len > 4095); pw_v = pw_o ? 12'd4095 : 12'(len);
                end else if (rise) begin
                    pp = 1; pp_o = (len > 4095); pp_v = pp_o ? 12'd4095 : 12'(len);
                    m_rise_edge = cyc;
                end
            end
            e_busy = (m_mode == 2);
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got=%0d exp=%0d", name, $time, got, exp);
        end
    endtask

    logic [12:0] got_w[$];
    logic [12:0] got_p[$];

    always @(negedge clk) begin
        if (m_started) begin
            chk("width",  32'(o_width),  32'(e_width));
            chk("wvalid", 32'(o_wvalid), 32'(e_wvalid));
            chk("wovf",   32'(o_wovf),   32'(e_wovf));
            chk("period", 32'(o_period), 32'(e_period));
            chk("pvalid", 32'(o_pvalid), 32'(e_pvalid));
            chk("povf",   32'(o_povf),   32'(e_povf));
            chk("busy",   32'(o_busy),   32'(e_busy));
            if (o_wvalid === 1'b1) got_w.push_back({o_wovf, o_width});
            if (o_pvalid === 1'b1) got_p.push_back({o_povf, o_period});
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic drive(input logic v, input int n);
        i_pwm = v;
        step(n);
    endtask

    task automatic quiesce();
        i_en = 1'b0;
        i_pwm = 1'b0;
        step(4);
        got_w.delete();
        got_p.delete();
        i_en = 1'b1;
        step(4);
    endtask

    task automatic chk_reports(input string name, input logic [12:0] ew[$], input logic [12:0] ep[$]);
        chk({name, "_nw"}, 32'(got_w.size()), 32'(ew.size()));
        chk({name, "_np"}, 32'(got_p.size()), 32'(ep.size()));
        for (int i = 0; i < ew.size() && i < got_w.size(); i++)
            chk({name, "_w"}, 32'(got_w[i]), 32'(ew[i]));
        for (int i = 0; i < ep.size() && i < got_p.size(); i++)
            chk({name, "_p"}, 32'(got_p[i]), 32'(ep[i]));
    endtask

    initial begin
        logic [12:0] ew[$];
        logic [12:0] ep[$];
        rst = 1'b1; i_en = 1'b0; i_pwm = 1'b0;
        step(3);
        chk("rst_width", 32'(o_width), 0);
        chk("rst_busy",  32'(o_busy),  0);
        rst = 1'b0;

        // Basic 10 high / 20 low / 10 high
        quiesce();
        drive(1, 10); drive(0, 20); drive(1, 10); drive(0, 5);
        ew = '{13'd10, 13'd10}; ep = '{13'd30};
        chk_reports("t1", ew, ep);

        // Minimum 1-cycle high and low
        quiesce();
        repeat (8) begin drive(1, 1); drive(0, 1); end
        drive(0, 4);
        ew = '{13'd1, 13'd1, 13'd1, 13'd1, 13'd1, 13'd1, 13'd1, 13'd1};
        ep = '{13'd2, 13'd2, 13'd2, 13'd2, 13'd2, 13'd2, 13'd2};
        chk_reports("t2", ew, ep);

        // Saturation
        quiesce();
        drive(1, 5000); drive(0, 10); drive(1, 3); drive(0, 5);
        ew = '{13'h1FFF, 13'd3}; ep = '{13'h1FFF};
        chk_reports("t3", ew, ep);

        // Line already high when enabled
        i_en = 1'b0; i_pwm = 1'b1;
        step(6);
        got_w.delete(); got_p.delete();
        i_en = 1'b1;
        step(8);
        drive(0, 6); drive(1, 4); drive(0, 6); drive(1, 2); drive(0, 5);
        ew = '{13'd4, 13'd2}; ep = '{13'd10};
        chk_reports("t4", ew, ep);

        // Enable dropped mid-high
        i_en = 1'b0; step(4);
        i_en = 1'b1; step(4);
        got_w.delete(); got_p.delete();
        drive(1, 7);
        chk("t5_busy_before", 32'(o_busy), 1);
        i_en = 1'b0;
        step(1);
        chk("t5_busy_after", 32'(o_busy), 0);
        chk("t5_width_held", 32'(o_width), 2);
        drive(0, 5);
        ew = {}; ep = {};
        chk_reports("t5", ew, ep);

        // Reset while in the low phase
        i_en = 1'b1; step(4);
        drive(1, 5); drive(0, 6);
        chk("t6_width_pre", 32'(o_width), 5);
        rst = 1'b1;
        step(1);
        chk("t6_rst_width",  32'(o_width),  0);
        chk("t6_rst_period", 32'(o_period), 0);
        chk("t6_rst_valid",  32'({o_wvalid, o_pvalid, o_wovf, o_povf}), 0);
        chk("t6_rst_busy",   32'(o_busy),   0);
        rst = 1'b0;
        got_w.delete(); got_p.delete();
        drive(0, 4); drive(1, 12); drive(0, 5);
        ew = '{13'd12}; ep = {};
        chk_reports("t6", ew, ep);

        // Randomized traffic against the model
        quiesce();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 40) == 0) begin
                i_en = 1'b0; step($urandom_range(1, 3)); i_en = 1'b1;
            end
            if ($urandom_range(0, 120) == 0) begin
                rst = 1'b1; step(1); rst = 1'b0;
            end
            i_pwm = ~i_pwm;
            if ($urandom_range(0, 150) == 0) step($urandom_range(4090, 4100));
            else step($urandom_range(1, 14));
        end
        step(6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
